// File: rtl/fxp_add_scheduler_pkg.sv
// Shared types and helpers for the fixed-point adder scheduler.
// Holds the FSM state encoding and a constant-foldable clog2.
package fxp_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Bits needed to index 'value' items; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    localparam int DEF_NREQ = 4;
    localparam int ID_W     = clog2(DEF_NREQ);

endpackage

// File: rtl/fxp_add_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the requester just after last_grant
// has the highest priority, wrapping modulo NREQ.
module rr_arbiter
    import fxp_sched_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    localparam logic [IDW:0] NREQ_V = (IDW+1)'(NREQ);

    logic [IDW-1:0]  cand [NREQ];
    logic [NREQ-1:0] hit;

    // cand[gi] is the requester sitting gi+1 places after last_grant.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rot
            localparam logic [IDW:0] OFS = (IDW+1)'(gi + 1);
            logic [IDW:0] sum;
            assign sum       = {1'b0, last_grant} + OFS;
            assign cand[gi]  = (sum >= NREQ_V) ? IDW'(sum - NREQ_V) : IDW'(sum);
            assign hit[gi]   = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                gnt_idx = cand[k];
                any     = 1'b1;
            end
        end
        if (any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/fxp_add_scheduler.sv
// Time-shares one external fixed-point adder among NREQ requesters:
// round-robin accept, operand latch, ADD_LAT-cycle start, tagged response.
module fxp_add_scheduler
    import fxp_sched_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int WI      = 4,
    parameter  int WF      = 4,
    parameter  int WIO     = 4,
    parameter  int WFO     = 4,
    parameter  int ADD_LAT = 1,
    localparam int IDW     = clog2(NREQ),
    localparam int WOP     = WI + WF,
    localparam int WRES    = WIO + WFO
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*WOP-1:0] req_a,
    input  logic [NREQ*WOP-1:0] req_b,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [WRES-1:0]     rsp_data,
    output logic                rsp_ovf,
    output logic                add_start,
    output logic [WOP-1:0]      add_in1,
    output logic [WOP-1:0]      add_in2,
    input  logic [WRES-1:0]     add_out,
    input  logic                add_ovf
);

    localparam int             LAT_W    = (clog2(ADD_LAT) < 1) ? 1 : clog2(ADD_LAT);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ADD_LAT - 1);
    localparam logic [IDW-1:0]   LAST_INIT = IDW'(NREQ - 1);

    state_e            state_reg, state_next;
    logic [IDW-1:0]    last_grant_reg, last_grant_next;
    logic [LAT_W-1:0]  lat_cnt_reg, lat_cnt_next;
    logic [WOP-1:0]    op_a_reg, op_a_next;
    logic [WOP-1:0]    op_b_reg, op_b_next;
    logic [IDW-1:0]    id_reg, id_next;
    logic [WRES-1:0]   rsp_data_reg, rsp_data_next;
    logic              rsp_ovf_reg, rsp_ovf_next;

    logic [NREQ-1:0]   arb_gnt;
    logic [IDW-1:0]    arb_idx;
    logic              arb_any;

    logic [WOP-1:0]    a_lane [NREQ];
    logic [WOP-1:0]    b_lane [NREQ];

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req        (req_valid),
        .last_grant (last_grant_reg),
        .gnt        (arb_gnt),
        .gnt_idx    (arb_idx),
        .any        (arb_any)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_lane
            assign a_lane[gi] = req_a[gi*WOP +: WOP];
            assign b_lane[gi] = req_b[gi*WOP +: WOP];
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        last_grant_next = last_grant_reg;
        lat_cnt_next    = lat_cnt_reg;
        op_a_next       = op_a_reg;
        op_b_next       = op_b_reg;
        id_next         = id_reg;
        rsp_data_next   = rsp_data_reg;
        rsp_ovf_next    = rsp_ovf_reg;
        case (state_reg)
            ST_IDLE: begin
                if (arb_any) begin
                    op_a_next    = a_lane[arb_idx];
                    op_b_next    = b_lane[arb_idx];
                    id_next      = arb_idx;
                    lat_cnt_next = LAT_INIT;
                    state_next   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (lat_cnt_reg == '0) begin
                    rsp_data_next = add_out;
                    rsp_ovf_next  = add_ovf;
                    state_next    = ST_RESP;
                end else begin
                    lat_cnt_next = lat_cnt_reg - 1'b1;
                end
            end
            ST_RESP: begin
                // Rotation only advances once the result has actually left.
                if (rsp_ready) begin
                    last_grant_next = id_reg;
                    state_next      = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= LAST_INIT;
            lat_cnt_reg    <= '0;
            op_a_reg       <= '0;
            op_b_reg       <= '0;
            id_reg         <= '0;
            rsp_data_reg   <= '0;
            rsp_ovf_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_grant_reg <= last_grant_next;
            lat_cnt_reg    <= lat_cnt_next;
            op_a_reg       <= op_a_next;
            op_b_reg       <= op_b_next;
            id_reg         <= id_next;
            rsp_data_reg   <= rsp_data_next;
            rsp_ovf_reg    <= rsp_ovf_next;
        end
    end

    // Accept pulse is masked while reset is held so no requester sees a phantom grant.
    assign req_ready = (state_reg == ST_IDLE && !reset) ? arb_gnt : '0;
    assign add_start = (state_reg == ST_RUN);
    assign add_in1   = op_a_reg;
    assign add_in2   = op_b_reg;
    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_id    = id_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_ovf   = rsp_ovf_reg;

endmodule

// File: tb/tb_fxp_add_scheduler.sv
// Self-checking bench: directed and randomized traffic against a
// transaction-level model of the scheduler, plus a reset/latency check at ADD_LAT=4.
module tb_fxp_add_scheduler;

    localparam int LAT1 = 1;
    localparam int LAT4 = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // ---------------- DUT with ADD_LAT = 1 ----------------
    logic        reset;
    logic [3:0]  req_valid, req_ready;
    logic [31:0] req_a, req_b;
    logic        rsp_valid, rsp_ready, rsp_ovf;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic        add_start, add_ovf;
    logic [7:0]  add_in1, add_in2, add_out;
    logic [7:0]  op_a [4];
    logic [7:0]  op_b [4];

    fxp_add_scheduler #(.NREQ(4), .WI(4), .WF(4), .WIO(4), .WFO(4), .ADD_LAT(LAT1)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_ovf(rsp_ovf),
        .add_start(add_start), .add_in1(add_in1), .add_in2(add_in2),
        .add_out(add_out), .add_ovf(add_ovf)
    );

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < 4; i++) begin
            req_a[i*8 +: 8] = op_a[i];
            req_b[i*8 +: 8] = op_b[i];
        end
    end

    // Signed 4.4 + 4.4 -> 4.4 with two's-complement overflow flag: {ovf, sum}.
    function automatic logic [8:0] ref_add(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] s;
        s = a + b;
        return {(a[7] == b[7]) && (s[7] != a[7]), s};
    endfunction

    // External adder: result is only correct on the last start cycle, garbage otherwise.
    logic [3:0] acnt;
    logic [8:0] asum;
    always_ff @(posedge clk) begin
        if (reset || !add_start) acnt <= '0;
        else                     acnt <= acnt + 4'd1;
    end
    assign asum    = ref_add(add_in1, add_in2);
    assign add_out = (add_start && acnt == 4'(LAT1 - 1)) ? asum[7:0] : asum[7:0] ^ 8'h5A;
    assign add_ovf = (add_start && acnt == 4'(LAT1 - 1)) ? asum[8] : ~asum[8];

    // ---------------- DUT with ADD_LAT = 4 ----------------
    logic        reset4;
    logic [3:0]  req_valid4, req_ready4;
    logic [31:0] req_a4, req_b4;
    logic        rsp_valid4, rsp_ready4, rsp_ovf4;
    logic [1:0]  rsp_id4;
    logic [7:0]  rsp_data4;
    logic        add_start4, add_ovf4;
    logic [7:0]  add_in14, add_in24, add_out4;

    fxp_add_scheduler #(.NREQ(4), .WI(4), .WF(4), .WIO(4), .WFO(4), .ADD_LAT(LAT4)) u_dut4 (
        .clk(clk), .reset(reset4),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_a(req_a4), .req_b(req_b4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_id(rsp_id4),
        .rsp_data(rsp_data4), .rsp_ovf(rsp_ovf4),
        .add_start(add_start4), .add_in1(add_in14), .add_in2(add_in24),
        .add_out(add_out4), .add_ovf(add_ovf4)
    );

    logic [3:0] acnt4;
    logic [8:0] asum4;
    always_ff @(posedge clk) begin
        if (reset4 || !add_start4) acnt4 <= '0;
        else                       acnt4 <= acnt4 + 4'd1;
    end
    assign asum4    = ref_add(add_in14, add_in24);
    assign add_out4 = (add_start4 && acnt4 == 4'(LAT4 - 1)) ? asum4[7:0] : asum4[7:0] ^ 8'h5A;
    assign add_ovf4 = (add_start4 && acnt4 == 4'(LAT4 - 1)) ? asum4[8] : ~asum4[8];

    // ---------------- transaction-level model ----------------
    bit         m_busy;
    int         m_acc, m_last, m_id, hs_cyc;
    logic [7:0] m_a, m_b;
    bit         keep;
    int         acc_id[$];
    int         acc_cyc[$];
    logic [1:0] lr_id;
    logic [7:0] lr_data;
    logic       lr_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic post(input int i, input logic [7:0] a, input logic [7:0] b);
        op_a[i] = a;
        op_b[i] = b;
        req_valid[i] = 1'b1;
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_last = 3;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // One clock cycle: check every output against the model, then advance both.
    task automatic step();
        logic [3:0] exp_rdy;
        logic [8:0] exp_sum;
        int  g;
        bit  exp_st, exp_rv, hs;
        #1;
        exp_rdy = '0;
        g = -1;
        if (!m_busy) begin
            for (int k = 1; k <= 4; k++) begin
                if (g < 0 && req_valid[(m_last + k) % 4]) g = (m_last + k) % 4;
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        chk("req_ready", {28'd0, req_ready}, {28'd0, exp_rdy});
        exp_st = m_busy && (cyc > m_acc) && (cyc <= m_acc + LAT1);
        chk("add_start", {31'd0, add_start}, {31'd0, exp_st});
        if (exp_st) begin
            chk("add_in1", {24'd0, add_in1}, {24'd0, m_a});
            chk("add_in2", {24'd0, add_in2}, {24'd0, m_b});
        end
        exp_rv = m_busy && (cyc >= m_acc + 1 + LAT1);
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_rv});
        if (exp_rv) begin
            exp_sum = ref_add(m_a, m_b);
            chk("rsp_id", {30'd0, rsp_id}, m_id);
            chk("rsp_data", {24'd0, rsp_data}, {24'd0, exp_sum[7:0]});
            chk("rsp_ovf", {31'd0, rsp_ovf}, {31'd0, exp_sum[8]});
        end
        hs = exp_rv && rsp_ready;
        if (hs) begin
            lr_id = rsp_id; lr_data = rsp_data; lr_ovf = rsp_ovf; hs_cyc = cyc;
            $display("cyc %0d rsp id=%0d a=%02h b=%02h data=%02h ovf=%0d",
                     cyc, rsp_id, m_a, m_b, rsp_data, rsp_ovf);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (hs) begin
            m_busy = 1'b0;
            m_last = m_id;
        end
        if (g >= 0) begin
            m_busy = 1'b1;
            m_acc  = cyc - 1;
            m_id   = g;
            m_a    = op_a[g];
            m_b    = op_b[g];
            acc_id.push_back(g);
            acc_cyc.push_back(cyc - 1);
            if (!keep) req_valid[g] = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b1; reset4 = 1'b1;
        req_valid = '0; rsp_ready = 1'b0; keep = 1'b0;
        req_valid4 = '0; rsp_ready4 = 1'b0; req_a4 = '0; req_b4 = '0;
        for (int i = 0; i < 4; i++) begin op_a[i] = '0; op_b[i] = '0; end
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        chk("rst_req_ready", {28'd0, req_ready}, 0);
        chk("rst_add_start", {31'd0, add_start}, 0);
        chk("rst_add_in1", {24'd0, add_in1}, 0);
        chk("rst_add_in2", {24'd0, add_in2}, 0);
        chk("rst_rsp_id", {30'd0, rsp_id}, 0);
        chk("rst_rsp_data", {24'd0, rsp_data}, 0);
        chk("rst_rsp_ovf", {31'd0, rsp_ovf}, 0);
        reset = 1'b0; reset4 = 1'b0;

        // Basic add on requester 0.
        rsp_ready = 1'b1;
        post(0, 8'h18, 8'h24);
        repeat (5) step();
        chk("basic_id", {30'd0, lr_id}, 0);
        chk("basic_data", {24'd0, lr_data}, 32'h3C);
        chk("basic_ovf", {31'd0, lr_ovf}, 0);

        // Overflow on requester 2.
        post(2, 8'h70, 8'h20);
        repeat (5) step();
        chk("ovf_id", {30'd0, lr_id}, 2);
        chk("ovf_data", {24'd0, lr_data}, 32'h90);
        chk("ovf_flag", {31'd0, lr_ovf}, 1);

        // Round-robin with all four continuously valid.
        do_reset();
        acc_id.delete(); acc_cyc.delete();
        keep = 1'b1;
        for (int i = 0; i < 4; i++) post(i, 8'($urandom), 8'($urandom));
        repeat (16) step();
        keep = 1'b0;
        req_valid = '0;
        repeat (4) step();
        chk("rr_count_ge5", {31'd0, acc_id.size() >= 5}, 1);
        if (acc_id.size() >= 5) begin
            for (int k = 0; k < 5; k++) chk("rr_order", acc_id[k], k % 4);
            for (int k = 1; k < 5; k++) chk("rr_spacing", acc_cyc[k] - acc_cyc[k-1], LAT1 + 2);
        end

        // Backpressure: response held while requester 3 waits.
        do_reset();
        acc_id.delete(); acc_cyc.delete();
        rsp_ready = 1'b0;
        post(1, 8'h0F, 8'hF1);
        post(3, 8'h33, 8'h44);
        repeat (8) step();
        rsp_ready = 1'b1;
        step();
        step();
        chk("bp_accepts", acc_id.size(), 2);
        if (acc_id.size() == 2) begin
            chk("bp_second_id", acc_id[1], 3);
            chk("bp_next_accept", acc_cyc[1], hs_cyc + 1);
        end
        repeat (4) step();

        // Randomized traffic with random drops and backpressure.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) post(i, 8'($urandom), 8'($urandom));
                else if (req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
            end
            rsp_ready = 1'($urandom_range(0, 1));
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (6) step();
        chk("drain_idle", {31'd0, m_busy}, 0);

        // ADD_LAT=4: exact start window, stable operands, latency T+1+ADD_LAT.
        req_a4 = {8'h44, 8'h11, 8'h22, 8'h33};
        req_b4 = {8'h01, 8'h22, 8'h02, 8'h03};
        req_valid4 = 4'b0100;
        #1;
        chk("l4_ready", {28'd0, req_ready4}, 32'h4);
        @(posedge clk); #1;
        req_valid4 = '0;
        for (int k = 0; k < LAT4; k++) begin
            chk("l4_start", {31'd0, add_start4}, 1);
            chk("l4_in1", {24'd0, add_in14}, 32'h11);
            chk("l4_in2", {24'd0, add_in24}, 32'h22);
            chk("l4_rsp_early", {31'd0, rsp_valid4}, 0);
            @(posedge clk); #1;
        end
        chk("l4_start_off", {31'd0, add_start4}, 0);
        chk("l4_rsp_valid", {31'd0, rsp_valid4}, 1);
        chk("l4_rsp_id", {30'd0, rsp_id4}, 2);
        chk("l4_rsp_data", {24'd0, rsp_data4}, 32'h33);
        chk("l4_rsp_ovf", {31'd0, rsp_ovf4}, 0);
        $display("cyc %0d rsp4 id=%0d data=%02h ovf=%0d", cyc, rsp_id4, rsp_data4, rsp_ovf4);
        rsp_ready4 = 1'b1;
        @(posedge clk); #1;
        rsp_ready4 = 1'b0;
        chk("l4_rsp_done", {31'd0, rsp_valid4}, 0);

        // Reset during the second RUN cycle drops the operation.
        req_valid4 = 4'b1111;
        #1;
        chk("l4_rr_next", {28'd0, req_ready4}, 32'h8);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset4 = 1'b1;
        @(posedge clk); #1;
        chk("mr_rsp_valid", {31'd0, rsp_valid4}, 0);
        chk("mr_add_start", {31'd0, add_start4}, 0);
        chk("mr_add_in1", {24'd0, add_in14}, 0);
        chk("mr_add_in2", {24'd0, add_in24}, 0);
        chk("mr_rsp_id", {30'd0, rsp_id4}, 0);
        chk("mr_rsp_data", {24'd0, rsp_data4}, 0);
        chk("mr_rsp_ovf", {31'd0, rsp_ovf4}, 0);
        chk("mr_req_ready", {28'd0, req_ready4}, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("mr_no_rsp", {31'd0, rsp_valid4}, 0);
        reset4 = 1'b0;
        #1;
        chk("mr_grant_req0", {28'd0, req_ready4}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
